framebuffer_writer: RTL and testbench
=====================================

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, visible pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 120, visible pixel rows.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel buffer entries (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port px_valid  input  1  producer presents a pixel.
REQ-007 SHALL have port px_ready  output  1  block can accept a pixel.
REQ-008 SHALL have ports px_x (input, 8), px_y (input, 7) and px_colour (input, 3), giving the pixel coordinate and colour.
REQ-009 SHALL have port clear_req  input  1  single-cycle request to fill the screen.
REQ-010 SHALL have port clear_colour  input  3  fill colour, sampled with clear_req.
REQ-011 SHALL have ports fb_addr (output, 15), fb_data (output, 3) and fb_we (output, 1), forming the frame-buffer write port.
REQ-012 SHALL have port clear_done  output  1  one-cycle pulse when the fill completes.
REQ-013 SHALL have port busy  output  1  FIFO non-empty, clear pending, or clear active.
REQ-014 SHALL have port drop_count  output  8  saturating count of off-screen pixels.

Function
REQ-015 SHALL accept a pixel on a rising edge where px_valid and px_ready are both 1.
REQ-016 SHALL push accepted pixels into a FIFO of FIFO_DEPTH entries {x,y,colour}.
REQ-017 SHALL drive px_ready = !fifo_full && !clear_pending && state!=CLEAR, computed from registered state only.
REQ-018 SHALL refuse a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-019 SHALL have FSM states IDLE and CLEAR.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop one entry per cycle.
REQ-021 SHALL register the popped pixel to the write port: fb_addr = y*SCREEN_W + x (15-bit, no truncation), fb_data = colour, fb_we = 1.
REQ-022 SHALL, for a pixel accepted at edge k into an empty FIFO, pop it at edge k+1 and hold fb_we high for exactly one cycle from edge k+1.
REQ-023 SHALL drop a popped pixel with x >= SCREEN_W or y >= SCREEN_H: fb_we stays 0 and drop_count increments, saturating at 255.
REQ-024 SHALL drive fb_we = 0 in any cycle with no pop or clear write; fb_addr and fb_data are don't-care while fb_we = 0.
REQ-025 SHALL, on clear_req = 1 in IDLE, set clear_pending and latch clear_colour; px_ready drops from the next cycle.
REQ-026 SHALL enter CLEAR from IDLE once clear_pending is set and the FIFO is empty; pixels already queued are written before the fill.
REQ-027 SHALL, in CLEAR, assert fb_we every cycle with fb_addr counting 0 to SCREEN_W*SCREEN_H-1 (19199 by default) and fb_data = latched colour.
REQ-028 SHALL, after the last fill address, return to IDLE, clear clear_pending, pulse clear_done for one cycle, and re-assert px_ready in the cycle after the clear_done pulse.
REQ-029 SHALL ignore clear_req while clear_pending or CLEAR is active; no second fill is queued.
REQ-030 SHALL, when clear_req and an accepted pixel coincide, queue the pixel and write it before the fill.

Reset
REQ-031 SHALL, while resetn = 0 and asynchronously, empty the FIFO, set state IDLE, and clear clear_pending, the fill counter and drop_count.
REQ-032 SHALL, while resetn = 0, hold fb_we=0, fb_addr=0, fb_data=0, clear_done=0, busy=0 and px_ready=0.
REQ-033 SHALL, when reset is asserted mid-clear or mid-drain, abort the operation without completing it and discard all queued pixels.
REQ-034 SHALL assert px_ready on the first rising edge after resetn is released.

Verification
REQ-035 SHALL verify: accept (10,5,3'b101) at edge k -> fb_we=1 for one cycle after edge k+1, fb_addr=810, fb_data=5.
REQ-036 SHALL verify: pixels (159,119) then (160,0) -> one write at fb_addr=19199; second pixel is not written; drop_count=1.
REQ-037 SHALL verify: clear_req with colour 3'b010 -> 19200 consecutive fb_we cycles at addr 0..19199 with data 2, one clear_done pulse, then px_ready=1.
REQ-038 SHALL verify: 3 pixels queued when clear_req arrives -> all 3 written first, then the fill; pixels held at px_valid during the fill are accepted only after clear_done.
REQ-039 SHALL verify: resetn pulsed low at fill address 1000 -> fb_we=0 immediately, busy=0, no clear_done; px_ready=1 after release.
REQ-040 SHALL verify: 300 off-screen pixels -> drop_count=255 with no writes.

Source files
------------

// File: rtl/framebuffer_writer.sv
// Pixel writer for a frame buffer: queues incoming pixels, drops off-screen ones,
// and fills the whole screen with one colour when asked to clear.
//
// state  | meaning
// IDLE   | drain the pixel FIFO one entry per cycle; start a pending fill once the FIFO is empty
// CLEAR  | write the latched colour to every screen address, 0 up to the last one
module framebuffer_writer #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [7:0]  px_x,
  input  logic [6:0]  px_y,
  input  logic [2:0]  px_colour,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  output logic        clear_done,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LP_LAST = 15'(SCREEN_W * SCREEN_H - 1);
  localparam logic [15:0] LP_W    = 16'(SCREEN_W);
  localparam logic [15:0] LP_H    = 16'(SCREEN_H);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [17:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [0:0]  r_state;
  logic        r_alive;
  logic        r_clear_pending;
  logic [2:0]  r_clear_colour;
  logic [14:0] r_fill_cnt;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [17:0] w_head;
  logic [7:0]  w_hx;
  logic [6:0]  w_hy;
  logic [2:0]  w_hc;
  logic        w_offscreen;
  logic [14:0] w_pix_addr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // r_alive keeps ready low through reset; clear_done holds it off for the pulse cycle.
  assign px_ready = r_alive && !w_full && !r_clear_pending &&
                    (r_state != S_CLEAR) && !clear_done;
  assign busy     = !w_empty || r_clear_pending || (r_state == S_CLEAR);

  assign w_push = px_valid && px_ready;
  assign w_pop  = (r_state == S_IDLE) && !w_empty;

  assign w_head            = r_mem[r_rd_ptr[AW-1:0]];
  assign {w_hx, w_hy, w_hc} = w_head;
  assign w_offscreen       = ({8'd0, w_hx} >= LP_W) || ({9'd0, w_hy} >= LP_H);
  assign w_pix_addr        = 15'(w_hy) * 15'(SCREEN_W) + 15'(w_hx);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {px_x, px_y, px_colour};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_state         <= S_IDLE;
      r_alive         <= 1'b0;
      r_clear_pending <= 1'b0;
      r_clear_colour  <= 3'd0;
      r_fill_cnt      <= 15'd0;
      fb_addr         <= 15'd0;
      fb_data         <= 3'd0;
      fb_we           <= 1'b0;
      clear_done      <= 1'b0;
      drop_count      <= 8'd0;
    end else begin
      r_alive    <= 1'b1;
      fb_we      <= 1'b0;
      clear_done <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_offscreen) begin
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else begin
              fb_we   <= 1'b1;
              fb_addr <= w_pix_addr;
              fb_data <= w_hc;
            end
          end else if (r_clear_pending) begin
            r_state    <= S_CLEAR;
            r_fill_cnt <= 15'd0;
          end
          if (clear_req && !r_clear_pending) begin
            r_clear_pending <= 1'b1;
            r_clear_colour  <= clear_colour;
          end
        end
        S_CLEAR: begin
          fb_we   <= 1'b1;
          fb_addr <= r_fill_cnt;
          fb_data <= r_clear_colour;
          if (r_fill_cnt == LP_LAST) begin
            r_state         <= S_IDLE;
            r_clear_pending <= 1'b0;
            clear_done      <= 1'b1;
          end else begin
            r_fill_cnt <= r_fill_cnt + 15'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: pixel vector table plus clear/reset/drop sequences.
module tb_framebuffer_writer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [2:0]  px_colour;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        clear_done;
  logic        busy;
  logic [7:0]  drop_count;

  framebuffer_writer dut (
    .clk(clk), .resetn(resetn), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_colour(px_colour),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .clear_done(clear_done), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [14:0] a;
    logic [2:0]  d;
  } wr_t;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  drops;
  } vec_t;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  done_cnt = 0;
  wr_t wlog[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we) wlog.push_back('{cyc, fb_addr, fb_data});
    if (clear_done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    int  errs;
    int  done0;
    int  n;
    bit  found;
    bit  early_ready;
    logic [14:0] ea;
    logic [2:0]  ed;

    vecs[0] = '{8'd10,  7'd5,   3'd5, 1'b1, 15'd810,   8'd0};
    vecs[1] = '{8'd0,   7'd0,   3'd1, 1'b1, 15'd0,     8'd0};
    vecs[2] = '{8'd159, 7'd119, 3'd7, 1'b1, 15'd19199, 8'd0};
    vecs[3] = '{8'd160, 7'd0,   3'd3, 1'b0, 15'd0,     8'd1};
    vecs[4] = '{8'd0,   7'd120, 3'd2, 1'b0, 15'd0,     8'd2};
    vecs[5] = '{8'd255, 7'd127, 3'd4, 1'b0, 15'd0,     8'd3};
    vecs[6] = '{8'd1,   7'd1,   3'd6, 1'b1, 15'd161,   8'd3};
    vecs[7] = '{8'd100, 7'd60,  3'd0, 1'b1, 15'd9700,  8'd3};

    resetn = 1'b0; px_valid = 1'b0; px_x = '0; px_y = '0; px_colour = '0;
    clear_req = 1'b0; clear_colour = '0;
    repeat (3) step();
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_busy", busy, 0);
    check("rst_px_ready", px_ready, 0);
    check("rst_drop_count", drop_count, 0);
    #2 resetn = 1'b1;
    step();
    check("ready_after_release", px_ready, 1);

    // Single-pixel vectors: accept at edge k, write visible after k+1, gone after k+2.
    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d_ready", i), px_ready, 1);
      px_valid = 1'b1; px_x = vecs[i].x; px_y = vecs[i].y; px_colour = vecs[i].c;
      step();
      px_valid = 1'b0;
      step();
      check($sformatf("v%0d_we", i), fb_we, 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d_addr", i), fb_addr, 32'(vecs[i].addr));
        check($sformatf("v%0d_data", i), fb_data, 32'(vecs[i].c));
      end
      step();
      check($sformatf("v%0d_we_off", i), fb_we, 0);
      check($sformatf("v%0d_drops", i), drop_count, 32'(vecs[i].drops));
    end

    // Pixels queued around clear_req are written first, then the full fill, then held pixel.
    repeat (2) step();
    wlog.delete();
    done0 = done_cnt;
    px_valid = 1'b1; px_x = 8'd10; px_y = 7'd5; px_colour = 3'd5;
    step();
    px_x = 8'd1; px_y = 7'd1; px_colour = 3'd6;
    step();
    px_x = 8'd159; px_y = 7'd119; px_colour = 3'd7;
    clear_req = 1'b1; clear_colour = 3'b010;
    step();
    clear_req = 1'b0;
    px_x = 8'd2; px_y = 7'd0; px_colour = 3'd3;
    check("ready_low_after_clear_req", px_ready, 0);
    check("busy_pending", busy, 1);
    found = 1'b0;
    early_ready = 1'b0;
    for (n = 0; n < 20100 && !found; n++) begin
      step();
      clear_req = (n == 100);
      clear_colour = (n == 100) ? 3'b111 : 3'b010;
      if (clear_done) found = 1'b1;
      else if (px_ready) early_ready = 1'b1;
      if (n == 5000) check("busy_during_fill", busy, 1);
    end
    clear_req = 1'b0;
    check("clear_done_seen", found, 1);
    check("ready_low_during_fill", early_ready, 0);
    check("ready_at_done", px_ready, 0);
    step();
    check("ready_after_done", px_ready, 1);
    step();
    px_valid = 1'b0;
    repeat (4) step();
    check("clear_done_pulses", done_cnt - done0, 1);
    check("log_size", wlog.size(), 19204);
    if (wlog.size() == 19204) begin
      errs = 0;
      for (int j = 0; j < 19204; j++) begin
        if (j == 0) begin ea = 15'd810; ed = 3'd5; end
        else if (j == 1) begin ea = 15'd161; ed = 3'd6; end
        else if (j == 2) begin ea = 15'd19199; ed = 3'd7; end
        else if (j == 19203) begin ea = 15'd2; ed = 3'd3; end
        else begin ea = 15'(j - 3); ed = 3'b010; end
        if (wlog[j].a !== ea || wlog[j].d !== ed ||
            (j > 3 && j < 19203 && wlog[j].cyc != wlog[j-1].cyc + 1)) begin
          if (errs == 0)
            $display("FAIL write_seq idx=%0d actual addr=%0d data=%0d required addr=%0d data=%0d",
                     j, wlog[j].a, wlog[j].d, ea, ed);
          errs++;
        end
      end
      check("write_seq_errors", errs, 0);
    end

    // Reset asserted mid-fill aborts the fill.
    clear_req = 1'b1; clear_colour = 3'b110;
    step();
    clear_req = 1'b0;
    found = 1'b0;
    for (n = 0; n < 2000 && !found; n++) begin
      step();
      if (fb_we && fb_addr == 15'd1000) found = 1'b1;
    end
    check("fill_reached_1000", found, 1);
    done0 = done_cnt;
    #2 resetn = 1'b0;
    wlog.delete();
    #1;
    check("mid_rst_fb_we", fb_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", px_ready, 0);
    check("mid_rst_done", clear_done, 0);
    repeat (3) step();
    #2 resetn = 1'b1;
    step();
    check("mid_rst_ready_release", px_ready, 1);
    check("mid_rst_busy_release", busy, 0);
    repeat (30) step();
    check("mid_rst_no_writes", wlog.size(), 0);
    check("mid_rst_no_done", done_cnt - done0, 0);
    check("mid_rst_drops", drop_count, 0);

    // 300 off-screen pixels saturate drop_count with no writes.
    wlog.delete();
    px_valid = 1'b1; px_x = 8'd200; px_y = 7'd3; px_colour = 3'd1;
    n = 0;
    for (int k = 0; k < 1000 && n < 300; k++) begin
      found = px_ready;
      step();
      if (found) n++;
    end
    px_valid = 1'b0;
    check("drop_accepts", n, 300);
    repeat (4) step();
    check("drop_saturated", drop_count, 255);
    check("drop_no_writes", wlog.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
